// File: rtl/sdp_mem_stream_reader_pkg.sv
// sdp_reader_pkg: shared types for the memory stream reader.
//   state_t : reader FSM states (IDLE -> RUN -> DRAIN -> IDLE)
package sdp_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/sdp_mem_stream_reader_if.sv
// sdp_mem_stream_reader_if: valid/ready output stream of the reader.
//   m_valid : beat valid              (master -> slave)
//   m_ready : downstream accept       (slave -> master)
//   m_data  : beat word               (master -> slave)
//   m_last  : final beat of transfer  (master -> slave)
interface sdp_mem_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/sdp_mem_stream_reader_fifo.sv
// stream_sync_fifo: single-clock FIFO with first-word fall-through output.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   wr_en/wr_data : push (ignored when full)
//   rd_en      : pop of the head word (ignored when empty)
//   rd_data    : head word, stable until popped
//   empty      : no words held
module stream_sync_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 33
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_rd)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/simple_dual_port_mem.sv
// simple_dual_port_mem: simple dual-port RAM, write port A, read port B.
//   clka/ena/wea/addra/dina : synchronous write port
//   clkb/enb/addrb          : read port, address registered when enb=1
//   doutb                   : read data, two cycles after the addressed cycle
// Only the behavioural array is provided (BRAM_PRIMITIVE=0).
module simple_dual_port_mem #(
    parameter int DEPTH          = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int BRAM_PRIMITIVE = 0,
    localparam int ADDR_WIDTH    = $clog2(DEPTH)
)(
    input  logic                  clka,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic                  clkb,
    input  logic                  enb,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);
    if (BRAM_PRIMITIVE != 0) begin : g_no_primitive
        $fatal(1, "simple_dual_port_mem: only BRAM_PRIMITIVE=0 is available");
    end

    logic [DATA_WIDTH-1:0] ram [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    always_ff @(posedge clka) begin
        if (ena && wea) ram[addra] <= dina;
    end

    // Array read stage gated by enb, then an always-enabled output register.
    always_ff @(posedge clkb) begin
        if (enb) ram_q <= ram[addrb];
        doutb <= ram_q;
    end
endmodule

// File: rtl/sdp_mem_stream_reader.sv
// sdp_mem_stream_reader: reads length words starting at base_addr (wrapping
// at DEPTH) from a 2-cycle-latency memory and streams them out valid/ready.
//   clk, rst_n     : sole clock (also memory clkb), async active-low reset
//   start          : one-cycle request, ignored while busy
//   base_addr      : first word address
//   length         : word count 0..DEPTH (0 gives a bare done pulse)
//   busy, done     : transfer in progress / one-cycle completion pulse
//   mem_enb, mem_addrb, mem_doutb : memory read port
//   m              : output stream (m_valid, m_ready, m_data, m_last)
module sdp_mem_stream_reader
    import sdp_reader_pkg::*;
#(
    parameter int DEPTH       = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int LATENCY     = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [ADDR_WIDTH:0]      length,
    output logic                     busy,
    output logic                     done,
    output logic                     mem_enb,
    output logic [ADDR_WIDTH-1:0]    mem_addrb,
    input  logic [DATA_WIDTH-1:0]    mem_doutb,
    sdp_mem_stream_reader_if.master  m
);
    localparam int FIFO_DEPTH = LATENCY + 2;
    localparam int OW         = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    if (LATENCY != 2) begin : g_bad_latency
        $fatal(1, "sdp_mem_stream_reader: only LATENCY=2 is supported");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remain;
    logic [OW-1:0]         outstanding;
    logic [LATENCY-1:0]    vld_sr;
    logic [LATENCY-1:0]    last_sr;
    logic                  issue;
    logic                  pop;
    logic                  fifo_empty;
    logic [DATA_WIDTH:0]   fifo_head;

    // Outstanding counts reads until their beat leaves the FIFO, so capping it
    // at FIFO_DEPTH makes FIFO overflow impossible.
    assign issue     = (state == ST_RUN) && (outstanding < OW'(FIFO_DEPTH));
    assign pop       = m.m_valid && m.m_ready;
    assign busy      = (state != ST_IDLE);
    assign mem_enb   = busy;
    assign mem_addrb = addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr        <= '0;
            remain      <= '0;
            outstanding <= '0;
            vld_sr      <= '0;
            last_sr     <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            addr   <= base_addr;
                            remain <= length;
                            state  <= ST_RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr   <= (addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);
                        remain <= remain - REM_ONE;
                        if (remain == REM_ONE) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head[DATA_WIDTH]) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            case ({issue, pop})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase

            // The last flag rides alongside the read through the latency pipe.
            vld_sr  <= {vld_sr[LATENCY-2:0], issue};
            last_sr <= {last_sr[LATENCY-2:0], issue && (remain == REM_ONE)};
        end
    end

    stream_sync_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (vld_sr[LATENCY-1]),
        .wr_data ({last_sr[LATENCY-1], mem_doutb}),
        .rd_en   (m.m_ready),
        .rd_data (fifo_head),
        .empty   (fifo_empty)
    );

    assign m.m_valid = !fifo_empty;
    assign m.m_data  = fifo_head[DATA_WIDTH-1:0];
    assign m.m_last  = !fifo_empty && fifo_head[DATA_WIDTH];
endmodule

// File: tb/tb_sdp_mem_stream_reader.sv
module tb_sdp_mem_stream_reader;
    localparam int DEPTH = 5;
    localparam int DW    = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int FD    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_enb;
    logic [AW-1:0] mem_addrb;
    logic [DW-1:0] mem_doutb;
    logic          wea = 1'b0;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dina = '0;

    sdp_mem_stream_reader_if #(.DATA_WIDTH(DW)) s_if ();

    always #5 clk = ~clk;

    sdp_mem_stream_reader #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .LATENCY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .mem_enb   (mem_enb),
        .mem_addrb (mem_addrb),
        .mem_doutb (mem_doutb),
        .m         (s_if)
    );

    simple_dual_port_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .BRAM_PRIMITIVE(0)) u_mem (
        .clka  (clk),
        .ena   (wea),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .clkb  (clk),
        .enb   (mem_enb),
        .addrb (mem_addrb),
        .doutb (mem_doutb)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            beat_cnt = 0;
    int            done_cnt = 0;
    logic [DW:0]   exp_q [$];
    logic [DW-1:0] mem_model [DEPTH];
    bit            prev_stall = 0;
    logic [DW:0]   prev_beat;
    logic [DW:0]   e_beat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: scoreboard of beats, stall stability, done counting.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", s_if.m_valid, 1);
                check("stall_stable", {s_if.m_last, s_if.m_data}, prev_beat);
            end
            if (s_if.m_valid && s_if.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", s_if.m_valid, 0);
                end else begin
                    e_beat = exp_q.pop_front();
                    check("beat", {s_if.m_last, s_if.m_data}, e_beat);
                    beat_cnt++;
                end
            end
            prev_stall = s_if.m_valid && !s_if.m_ready;
            prev_beat  = {s_if.m_last, s_if.m_data};
        end
    end

    task automatic mem_wr(input int a, input logic [DW-1:0] d);
        wea = 1'b1; addra = AW'(a); dina = d;
        @(posedge clk); #1;
        wea = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            @(negedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_valid", s_if.m_valid, 0);
        end
    endtask

    // mode 0: m_ready held 1; 1: random m_ready; 2: m_ready 0 for 10 cycles then 1.
    task automatic run_xfer(input int base, input int len, input int mode, input bit ign);
        int cyc, first, b0, d0;
        bit got_done;
        for (int i = 0; i < len; i++)
            exp_q.push_back({(i == len - 1), mem_model[(base + i) % DEPTH]});
        b0 = beat_cnt; d0 = done_cnt; first = -1; cyc = 0; got_done = 0;
        base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got_done && cyc < 200) begin
            cyc++;
            case (mode)
                0:       s_if.m_ready = 1'b1;
                1:       s_if.m_ready = 1'($urandom_range(0, 1));
                default: s_if.m_ready = (cyc > 10);
            endcase
            if (ign) begin
                if (cyc == 2) begin start = 1'b1; base_addr = '0; length = 2; end
                else if (cyc == 3) start = 1'b0;
            end
            @(negedge clk); #1;
            if (first < 0 && s_if.m_valid) first = cyc;
            if (mode == 2 && cyc == 10) begin
                check("stall_addr", mem_addrb, (base + ((len < FD) ? len : FD)) % DEPTH);
                check("stall_has_data", s_if.m_valid, len > 0);
            end
            if (done) got_done = 1;
            else begin @(posedge clk); #1; end
        end
        check("done_seen", got_done, 1);
        check("done_count", done_cnt - d0, 1);
        check("beat_count", beat_cnt - b0, len);
        check("exp_drained", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        if (mode == 0) begin
            check("done_latency", cyc, (len == 0) ? 1 : len + 4);
            if (len > 0) check("first_valid_lat", first - 1, 3);
        end
        if (!got_done) exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_enb"}, mem_enb, 0);
        check({tag, "_addrb"}, mem_addrb, 0);
        check({tag, "_valid"}, s_if.m_valid, 0);
        check({tag, "_last"}, s_if.m_last, 0);
        check({tag, "_data"}, s_if.m_data, 0);
    endtask

    task automatic mid_reset();
        int b0, cyc;
        for (int i = 0; i < 5; i++)
            exp_q.push_back({(i == 4), mem_model[i % DEPTH]});
        b0 = beat_cnt; cyc = 0;
        base_addr = '0; length = 5; start = 1'b1; s_if.m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (beat_cnt - b0 < 2 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        check("rst_beats_before", beat_cnt - b0, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_all_zero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(12);
    endtask

    initial begin
        s_if.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) mem_wr(i, 32'h100 + i);
        idle(2);

        run_xfer(1, 3, 0, 0);
        idle(2);
        run_xfer(3, 5, 0, 0);
        run_xfer(0, 4, 2, 0);
        idle(1);
        run_xfer(2, 5, 2, 0);
        run_xfer(4, 0, 0, 0);
        idle(3);
        run_xfer(4, 3, 0, 1);
        idle(3);

        for (int i = 0; i < DEPTH; i++) mem_wr(i, $urandom);
        for (int t = 0; t < 24; t++) begin
            run_xfer($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH),
                     $urandom_range(0, 2), 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(2);
        mid_reset();
        run_xfer(0, 5, 0, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
